// File: rtl/sort_job_sched.sv
`timescale 1ns/1ps
// sort_job_sched: shares one heap-sort engine among NREQ requesters.
// Requests are latched into a pending vector, granted round-robin, and each
// grant runs the engine (held in reset outside a job) under a run timer.
// Every job ends with a one-cycle ack to its requester plus a timeout flag.
module sort_job_sched #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 1023,
    parameter int TW      = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] ack,
    output logic            job_err,
    output logic            busy,
    output logic [IDW-1:0]  grant_id,
    output logic [IDW-1:0]  rom_bank,
    output logic [IDW-1:0]  ram_bank,
    output logic            eng_rst,
    input  logic            eng_done,
    output logic [7:0]      jobs_cnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_RUN    = 2'd2,
        S_ACK    = 2'd3
    } state_t;

    localparam logic [TW-1:0]  TIMEOUT_T = TW'(TIMEOUT);
    localparam logic [TW-1:0]  BLANK_T   = TW'(2);
    localparam logic [IDW-1:0] LAST_ID   = IDW'(NREQ - 1);

    state_t          state_q;
    logic [NREQ-1:0] pending_q;
    logic [NREQ-1:0] pending_d;
    logic [IDW-1:0]  last_grant_q;
    logic [IDW-1:0]  grant_id_q;
    logic [IDW-1:0]  rom_bank_q;
    logic [IDW-1:0]  ram_bank_q;
    logic [NREQ-1:0] ack_q;
    logic            job_err_q;
    logic            busy_q;
    logic            eng_rst_q;
    logic [7:0]      jobs_cnt_q;
    logic [TW-1:0]   timer_q;

    logic            leave_ack;
    logic            pick_valid;
    logic [IDW-1:0]  pick_id;
    logic [IDW-1:0]  cand;

    assign leave_ack = (state_q == S_ACK);

    // Per-requester pending bit: a request sets it, the edge leaving this
    // requester's ACK clears it; a request on that same edge wins, so a
    // requester re-asking during its own ack is queued again.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_pend
            assign pending_d[gi] = req[gi] |
                (pending_q[gi] & ~(leave_ack && (grant_id_q == IDW'(gi))));
        end
    endgenerate

    // Round-robin pick: first pending id after last_grant, wrapping modulo
    // NREQ. Scanning from the farthest offset down lets the nearest win.
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        cand       = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IDW'((int'(last_grant_q) + k) % NREQ);
            if (pending_q[cand]) begin
                pick_valid = 1'b1;
                pick_id    = cand;
            end
        end
    end

    // Job FSM with registered outputs; reset drops any job in flight and
    // parks the engine in reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pending_q    <= '0;
            last_grant_q <= LAST_ID;
            grant_id_q   <= '0;
            rom_bank_q   <= '0;
            ram_bank_q   <= '0;
            ack_q        <= '0;
            job_err_q    <= 1'b0;
            busy_q       <= 1'b0;
            eng_rst_q    <= 1'b1;
            jobs_cnt_q   <= '0;
            timer_q      <= '0;
        end else begin
            pending_q <= pending_d;
            case (state_q)
                S_IDLE: begin
                    if (pick_valid) begin
                        grant_id_q   <= pick_id;
                        rom_bank_q   <= pick_id;
                        ram_bank_q   <= pick_id;
                        last_grant_q <= pick_id;
                        busy_q       <= 1'b1;
                        state_q      <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    timer_q   <= '0;
                    eng_rst_q <= 1'b0;
                    state_q   <= S_RUN;
                end
                S_RUN: begin
                    timer_q <= timer_q + 1'b1;
                    // The first two run cycles may still see the previous
                    // job's done level, so done only counts from timer 2.
                    if (eng_done && (timer_q >= BLANK_T)) begin
                        job_err_q  <= 1'b0;
                        ack_q      <= NREQ'(1) << grant_id_q;
                        eng_rst_q  <= 1'b1;
                        jobs_cnt_q <= jobs_cnt_q + 8'd1;
                        state_q    <= S_ACK;
                    end else if (timer_q == TIMEOUT_T) begin
                        job_err_q  <= 1'b1;
                        ack_q      <= NREQ'(1) << grant_id_q;
                        eng_rst_q  <= 1'b1;
                        jobs_cnt_q <= jobs_cnt_q + 8'd1;
                        state_q    <= S_ACK;
                    end
                end
                S_ACK: begin
                    ack_q     <= '0;
                    job_err_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ack      = ack_q;
    assign job_err  = job_err_q;
    assign busy     = busy_q;
    assign grant_id = grant_id_q;
    assign rom_bank = rom_bank_q;
    assign ram_bank = ram_bank_q;
    assign eng_rst  = eng_rst_q;
    assign jobs_cnt = jobs_cnt_q;

endmodule
